// File: rtl/branch_pred_table_pkg.sv
// Shared types and defaults for the global-history branch predictor.
// Counter encoding is the classic 2-bit saturating direction counter.
package branch_pred_table_pkg;

    localparam int HIST_BITS_DEF = 4;
    localparam int STAT_BITS_DEF = 16;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'd0;
    localparam ctr_t WNT = 2'd1;
    localparam ctr_t WT  = 2'd2;
    localparam ctr_t ST  = 2'd3;

endpackage

// File: rtl/branch_pred_table_if.sv
// Fetch/decode-facing signal bundle of the branch predictor.
// The predictor is the slave side; the pipeline (or a bench) is the master.
interface branch_pred_table_if #(
    parameter int HIST_BITS = 4,
    parameter int STAT_BITS = 16
);
    logic                 pred_req;
    logic                 pred_taken;
    logic [HIST_BITS-1:0] pred_idx;
    logic                 res_valid;
    logic                 res_taken;
    logic [HIST_BITS-1:0] res_idx;
    logic                 res_pred;
    logic                 mispredict;
    logic [STAT_BITS-1:0] br_count;
    logic [STAT_BITS-1:0] mp_count;

    modport slave (
        input  pred_req, res_valid, res_taken, res_idx, res_pred,
        output pred_taken, pred_idx, mispredict, br_count, mp_count
    );

    modport master (
        output pred_req, res_valid, res_taken, res_idx, res_pred,
        input  pred_taken, pred_idx, mispredict, br_count, mp_count
    );
endinterface

// File: rtl/branch_pred_table_bpt_regfile.sv
// Storage for the 2-bit direction counters: one write port, one read port at the
// write address, and a prediction read port that forwards a same-cycle write.
module bpt_regfile
    import branch_pred_table_pkg::*;
#(
    parameter int HIST_BITS = HIST_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [HIST_BITS-1:0] waddr,
    input  ctr_t                 wdata,
    output ctr_t                 wr_rdata,
    input  logic [HIST_BITS-1:0] raddr,
    output ctr_t                 rdata
);
    localparam int DEPTH = 1 << HIST_BITS;

    ctr_t mem_q [DEPTH];
    ctr_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= WNT;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Forwarding lets a branch resolving on the current history steer this cycle's prediction.
    always_comb begin
        wr_rdata = mem_q[waddr];
        rdata    = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end

endmodule

// File: rtl/branch_pred_table.sv
// Global-history branch predictor: GHR-indexed table of 2-bit counters,
// registered mispredict flag and saturating resolve/mispredict statistics.
module branch_pred_table
    import branch_pred_table_pkg::*;
#(
    parameter int HIST_BITS = HIST_BITS_DEF,
    parameter int STAT_BITS = STAT_BITS_DEF
) (
    input logic             clk,
    input logic             rst_n,
    branch_pred_table_if.slave bus
);
    localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic                 mispredict_q, mispredict_d;
    logic [STAT_BITS-1:0] br_count_q, br_count_d;
    logic [STAT_BITS-1:0] mp_count_q, mp_count_d;

    ctr_t ctr_cur;
    ctr_t ctr_upd;
    ctr_t ctr_pred;

    // pred_req carries no state effect; the prediction is always presented.
    logic pred_req_unused;
    assign pred_req_unused = bus.pred_req;

    bpt_regfile #(.HIST_BITS(HIST_BITS)) u_bpt (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (bus.res_valid),
        .waddr    (bus.res_idx),
        .wdata    (ctr_upd),
        .wr_rdata (ctr_cur),
        .raddr    (ghr_q),
        .rdata    (ctr_pred)
    );

    always_comb begin
        ctr_upd = ctr_cur;
        if (bus.res_taken) begin
            if (ctr_cur != ST) ctr_upd = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != SNT) ctr_upd = ctr_cur - 2'd1;
        end
    end

    always_comb begin
        ghr_d        = ghr_q;
        mispredict_d = 1'b0;
        br_count_d   = br_count_q;
        mp_count_d   = mp_count_q;
        if (bus.res_valid) begin
            ghr_d        = HIST_BITS'({ghr_q, bus.res_taken});
            mispredict_d = (bus.res_taken != bus.res_pred);
            if (br_count_q != STAT_MAX) br_count_d = br_count_q + STAT_BITS'(1);
            if (mispredict_d && (mp_count_q != STAT_MAX)) mp_count_d = mp_count_q + STAT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q        <= '0;
            mispredict_q <= 1'b0;
            br_count_q   <= '0;
            mp_count_q   <= '0;
        end else begin
            ghr_q        <= ghr_d;
            mispredict_q <= mispredict_d;
            br_count_q   <= br_count_d;
            mp_count_q   <= mp_count_d;
        end
    end

    assign bus.pred_idx   = ghr_q;
    assign bus.pred_taken = ctr_pred[1];
    assign bus.mispredict = mispredict_q;
    assign bus.br_count   = br_count_q;
    assign bus.mp_count   = mp_count_q;

endmodule
